// File: rtl/stream_pkg.sv
// Shared streaming constants and writer FSM state type.
// Used by the input reader and the output writer.
package stream_pkg;

  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = 512;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int BLOCK_BYTES     = 64;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    FILL,
    WRITE,
    DONE
  } writer_state_t;

  function automatic logic [7:0] burst_len(
    input logic [31:0] left,
    input logic [31:0] max_beats
  );
    return 8'(((left < max_beats) ? left : max_beats) - 32'd1);
  endfunction

endpackage

// File: rtl/stream_output_writer_word_packer.sv
// Packs 32-bit words into a 512-bit block by slot.
// Clearing zeroes the block, so a flushed partial block is zero-padded.
module word_packer
  import stream_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  wr_i,
  input  logic [WORD_BITS-1:0]  word_i,
  output logic [BLOCK_BITS-1:0] block_o,
  output logic [3:0]            slot_o
);

  logic [BLOCK_BITS-1:0] data_q;
  logic [3:0]            slot_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      data_q <= '0;
      slot_q <= '0;
    end else if (wr_i) begin
      data_q[{slot_q, 5'b0} +: WORD_BITS] <= word_i;
      slot_q <= slot_q + 4'd1;
    end
  end

  assign block_o = data_q;
  assign slot_o  = slot_q;

endmodule

// File: rtl/stream_output_writer.sv
// Drains PU result words into 512-bit blocks and writes them in bursts.
// STREAM_WRITER_DBUF_EN: two block buffers so filling overlaps writing.
module stream_output_writer
  import stream_pkg::*;
#(
  parameter int          NUM_PU      = 4,
  parameter int          NUM_OUTPUTS = 16,
  parameter int          BURST_BEATS = 16,
  parameter logic [15:0] WRITE_ID    = 16'd0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [63:0]                  output_base_addr,
  input  logic [NUM_PU-1:0][31:0]      output_word,
  input  logic [NUM_PU-1:0]            output_valid,
  output logic [NUM_PU-1:0]            output_ready,
  output logic [63:0]                  outputMemAddr,
  output logic                         outputMemAddrValid,
  output logic [7:0]                   outputMemAddrLen,
  output logic [15:0]                  outputMemAddrId,
  input  logic                         outputMemAddrReady,
  output logic [BLOCK_BITS-1:0]        outputMemBlock,
  output logic                         outputMemBlockValid,
  output logic                         outputMemBlockLast,
  input  logic                         outputMemBlockReady,
  output logic                         finished
);

  localparam int TW = NUM_PU * NUM_OUTPUTS;
  localparam int TB = (TW + WORDS_PER_BLOCK - 1) / WORDS_PER_BLOCK;
  localparam int PW = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  localparam logic [31:0] TW_L = 32'(TW);
  localparam logic [31:0] TB_L = 32'(TB);
  localparam logic [31:0] BB_L = 32'(BURST_BEATS);
  localparam logic [31:0] NO_L = 32'(NUM_OUTPUTS);
`ifdef STREAM_WRITER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic DB = (NB == 2);

  writer_state_t state_q, state_d;
  logic [63:0]   base_q, base_d;
  logic [63:0]   addr_q, addr_d;
  logic [31:0]   blocks_q, blocks_d;
  logic [31:0]   words_q, words_d;
  logic [31:0]   puw_q, puw_d;
  logic [PW-1:0] pu_q, pu_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    len_q, len_d;
  logic          av_q, av_d;
  logic          bv_q, bv_d;
  logic          last_q, last_d;
  logic          fin_q, fin_d;
  logic          fsel_q, fsel_d;
  logic          ssel_q, ssel_d;
  logic [1:0]    full_q, full_d;

  logic [BLOCK_BITS-1:0] pk_data [2];
  logic [3:0]            pk_slot [2];
  logic [1:0]            pk_wr, pk_clr;
  logic can_fill, accept, complete;
  logic addr_hs, beat_hs;

  for (genvar i = 0; i < NB; i++) begin : g_buf
    assign pk_wr[i]  = accept && (fsel_q == 1'(i));
    assign pk_clr[i] = beat_hs && (ssel_q == 1'(i));
    word_packer u_pk (
      .clk_i   (clock),
      .rst_i   (reset),
      .clr_i   (pk_clr[i]),
      .wr_i    (pk_wr[i]),
      .word_i  (output_word[pu_q]),
      .block_o (pk_data[i]),
      .slot_o  (pk_slot[i])
    );
  end
  if (NB == 1) begin : g_one
    assign pk_wr[1]   = 1'b0;
    assign pk_clr[1]  = 1'b0;
    assign pk_data[1] = '0;
    assign pk_slot[1] = '0;
  end

  // Double buffer keeps filling while a block waits on the bus.
  assign can_fill = DB
    ? ((state_q == FILL || state_q == WRITE) &&
       !full_q[fsel_q] && (words_q < TW_L))
    : (state_q == FILL);
  assign accept   = can_fill && output_valid[pu_q];
  assign complete = accept &&
    ((pk_slot[fsel_q] == 4'd15) || (words_q + 32'd1 == TW_L));
  assign addr_hs  = av_q && outputMemAddrReady;
  assign beat_hs  = bv_q && outputMemBlockReady;

  always_comb begin
    output_ready = '0;
    if (can_fill) output_ready[pu_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    blocks_d = blocks_q;
    words_d  = words_q;
    puw_d    = puw_q;
    pu_d     = pu_q;
    beat_d   = beat_q;
    len_d    = len_q;
    av_d     = av_q;
    bv_d     = bv_q;
    last_d   = last_q;
    fin_d    = fin_q;
    fsel_d   = fsel_q;
    ssel_d   = ssel_q;
    full_d   = full_q;
    if (accept) begin
      words_d = words_q + 32'd1;
      if (puw_q + 32'd1 == NO_L) begin
        puw_d = '0;
        pu_d  = pu_q + PW'(1);
      end else begin
        puw_d = puw_q + 32'd1;
      end
    end
    if (complete) begin
      full_d[fsel_q] = 1'b1;
      fsel_d = fsel_q ^ DB;
    end
    if (beat_hs) begin
      full_d[ssel_q] = 1'b0;
      ssel_d   = ssel_q ^ DB;
      blocks_d = blocks_q + 32'd1;
      bv_d     = 1'b0;
      last_d   = 1'b0;
    end
    unique case (state_q)
      IDLE: if (start) begin
        base_d   = output_base_addr;
        blocks_d = '0;
        words_d  = '0;
        puw_d    = '0;
        pu_d     = '0;
        beat_d   = '0;
        if (TB == 0) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          state_d = ADDR;
          av_d    = 1'b1;
          addr_d  = output_base_addr;
          len_d   = burst_len(TB_L, BB_L);
        end
      end
      ADDR: if (addr_hs) begin
        av_d   = 1'b0;
        beat_d = '0;
        if (DB && full_q[ssel_q]) begin
          state_d = WRITE;
          bv_d    = 1'b1;
          last_d  = (len_q == 8'd0);
        end else begin
          state_d = FILL;
        end
      end
      FILL: if (complete) begin
        state_d = WRITE;
        bv_d    = 1'b1;
        last_d  = (beat_q == len_q);
      end
      WRITE: if (beat_hs) begin
        if (beat_q == len_q) begin
          if (blocks_q + 32'd1 == TB_L) begin
            state_d = DONE;
            fin_d   = 1'b1;
          end else begin
            state_d = ADDR;
            av_d    = 1'b1;
            addr_d  = base_q + ({32'd0, blocks_q + 32'd1} << 6);
            len_d   = burst_len(TB_L - blocks_q - 32'd1, BB_L);
          end
        end else begin
          beat_d = beat_q + 8'd1;
          if (DB && (full_q[~ssel_q] ||
                     (complete && fsel_q != ssel_q))) begin
            bv_d   = 1'b1;
            last_d = (beat_q + 8'd1 == len_q);
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      blocks_q <= '0;
      words_q  <= '0;
      puw_q    <= '0;
      pu_q     <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      av_q     <= 1'b0;
      bv_q     <= 1'b0;
      last_q   <= 1'b0;
      fin_q    <= 1'b0;
      fsel_q   <= 1'b0;
      ssel_q   <= 1'b0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      blocks_q <= blocks_d;
      words_q  <= words_d;
      puw_q    <= puw_d;
      pu_q     <= pu_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      av_q     <= av_d;
      bv_q     <= bv_d;
      last_q   <= last_d;
      fin_q    <= fin_d;
      fsel_q   <= fsel_d;
      ssel_q   <= ssel_d;
      full_q   <= full_d;
    end
  end

  assign outputMemAddr       = addr_q;
  assign outputMemAddrValid  = av_q;
  assign outputMemAddrLen    = len_q;
  assign outputMemAddrId     = WRITE_ID;
  assign outputMemBlock      = pk_data[ssel_q];
  assign outputMemBlockValid = bv_q;
  assign outputMemBlockLast  = last_q;
  assign finished            = fin_q;

endmodule

// File: tb/tb_stream_output_writer.sv
// Randomized scoreboard bench for stream_output_writer.
// Honors STREAM_WRITER_DBUF_EN for the buffer-specific ready check.
module tb_stream_output_writer;
  import stream_pkg::*;

  localparam int NP = 2;
  localparam int NO = 20;
  localparam int BB = 2;
  localparam int TW = NP * NO;
  localparam int TB = (TW + 15) / 16;

  logic clock = 0;
  logic reset = 1;
  logic start = 0;
  logic z_start = 0;
  logic [63:0] base = '0;
  logic [NP-1:0][31:0] pword = '0;
  logic [NP-1:0] pvalid = '0;
  logic [NP-1:0] pready;
  logic [63:0] maddr;
  logic mav, mbv, mlast, fin;
  logic [7:0] mlen;
  logic [15:0] mid;
  logic [511:0] mblk;
  logic amr = 1;
  logic bmr = 1;

  logic [NP-1:0][31:0] zw = '0;
  logic [NP-1:0] zv = '1;
  logic [NP-1:0] z_rdy;
  logic [63:0] z_addr;
  logic z_av, z_bv, z_last, z_fin;
  logic [7:0] z_len;
  logic [15:0] z_id;
  logic [511:0] z_blk;

  always #5 clock = ~clock;

  stream_output_writer #(
    .NUM_PU(NP), .NUM_OUTPUTS(NO), .BURST_BEATS(BB), .WRITE_ID(16'd0)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .output_base_addr(base), .output_word(pword),
    .output_valid(pvalid), .output_ready(pready),
    .outputMemAddr(maddr), .outputMemAddrValid(mav),
    .outputMemAddrLen(mlen), .outputMemAddrId(mid),
    .outputMemAddrReady(amr), .outputMemBlock(mblk),
    .outputMemBlockValid(mbv), .outputMemBlockLast(mlast),
    .outputMemBlockReady(bmr), .finished(fin)
  );

  stream_output_writer #(
    .NUM_PU(NP), .NUM_OUTPUTS(0), .BURST_BEATS(BB), .WRITE_ID(16'd0)
  ) zdut (
    .clock(clock), .reset(reset), .start(z_start),
    .output_base_addr(base), .output_word(zw),
    .output_valid(zv), .output_ready(z_rdy),
    .outputMemAddr(z_addr), .outputMemAddrValid(z_av),
    .outputMemAddrLen(z_len), .outputMemAddrId(z_id),
    .outputMemAddrReady(1'b1), .outputMemBlock(z_blk),
    .outputMemBlockValid(z_bv), .outputMemBlockLast(z_last),
    .outputMemBlockReady(1'b1), .finished(z_fin)
  );

  typedef struct { logic [63:0] a; logic [7:0] l; } aexp_t;
  typedef struct { logic [511:0] d; logic last; } bexp_t;
  aexp_t aq[$];
  bexp_t bq[$];

  int checks = 0;
  int fails = 0;
  logic [31:0] pw [NP][NO];
  int idx [NP];
  bit drv_en = 0;
  int vmode = 0;
  int rmode = 0;
  int stall_a = 0;
  int stall_b = 0;
  logic [NP-1:0] drv_hs;
  logic rd_av, rd_bv;
  bit z_bad = 0;

  task automatic chk(input string n, input logic [511:0] act,
                     input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Expected bursts and beats from the flat drained word stream.
  task automatic push_model(input logic [63:0] b_addr);
    aexp_t ea;
    bexp_t eb;
    int j;
    for (int b = 0; b < TB; b += BB) begin
      ea.a = b_addr + 64'(64 * b);
      ea.l = 8'(((TB - b) < BB ? (TB - b) : BB) - 1);
      aq.push_back(ea);
    end
    for (int b = 0; b < TB; b++) begin
      eb.d = '0;
      for (int k = 0; k < 16; k++) begin
        j = 16 * b + k;
        if (j < TW) eb.d[32*k +: 32] = pw[j / NO][j % NO];
      end
      eb.last = ((b % BB) == BB - 1) || (b == TB - 1);
      bq.push_back(eb);
    end
  endtask

  initial forever begin
    @(negedge clock);
    drv_hs = pvalid & pready;
    @(posedge clock);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (!drv_en) begin
        pvalid[p] = 1'b0;
      end else begin
        if (drv_hs[p]) idx[p]++;
        if (idx[p] < NO) begin
          pvalid[p] = (vmode == 0) ? 1'b1 : ($urandom_range(3) != 0);
          pword[p]  = pw[p][idx[p]];
        end else begin
          pvalid[p] = 1'b0;
          pword[p]  = $urandom;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock);
    rd_av = mav;
    rd_bv = mbv;
    @(posedge clock);
    #1;
    if (stall_a > 0) begin
      amr = 1'b0;
      if (rd_av) stall_a--;
    end else begin
      amr = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
    end
    if (stall_b > 0) begin
      bmr = 1'b0;
      if (rd_bv) stall_b--;
    end else begin
      bmr = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
    end
  end

  logic [63:0] pa;
  logic [7:0] pl;
  logic [511:0] pb;
  logic pbl;
  bit apend, bpend, granted, fin_chk;
  int beats_left;
  aexp_t ma;
  bexp_t mb;

  initial forever begin
    @(negedge clock);
    if (z_av || z_bv || (z_rdy != 0)) z_bad = 1;
    if (reset) begin
      apend = 0; bpend = 0; granted = 0;
      fin_chk = 0; beats_left = 0;
    end else begin
      if (fin_chk) begin
        chk("finished after last beat", fin, 1);
        fin_chk = 0;
      end
      chk("output_ready onehot", ($countones(pready) <= 1), 1);
      if (!granted) chk("ready before addr handshake", pready, 0);
`ifndef STREAM_WRITER_DBUF_EN
      if (mbv) chk("ready while block pending", pready, 0);
`endif
      if (mav) begin
        if (apend) begin
          chk("addr stable", maddr, pa);
          chk("len stable", mlen, pl);
        end
        chk("addr while burst open", beats_left, 0);
        if (amr) begin
          if (aq.size() == 0) begin
            chk("unexpected addr", 1, 0);
          end else begin
            ma = aq.pop_front();
            chk("burst addr", maddr, ma.a);
            chk("burst len", mlen, ma.l);
            chk("burst id", mid, 0);
          end
          beats_left = int'(mlen) + 1;
          granted = 1;
          apend = 0;
        end else begin
          apend = 1; pa = maddr; pl = mlen;
        end
      end else if (apend) begin
        chk("addr valid dropped", 0, 1);
        apend = 0;
      end
      if (mbv) begin
        if (bpend) begin
          chk("block stable", mblk, pb);
          chk("last stable", mlast, pbl);
        end
        chk("data after addr", (beats_left > 0), 1);
        if (bmr) begin
          if (bq.size() == 0) begin
            chk("unexpected beat", 1, 0);
          end else begin
            mb = bq.pop_front();
            chk("beat data", mblk, mb.d);
            chk("beat last", mlast, mb.last);
            if (bq.size() == 0) fin_chk = 1;
          end
          beats_left--;
          bpend = 0;
        end else begin
          bpend = 1; pb = mblk; pbl = mlast;
        end
      end else if (bpend) begin
        chk("block valid dropped", 0, 1);
        bpend = 0;
      end
    end
  end

  task automatic run_start(input logic [63:0] b, input bit zs);
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < NO; i++) pw[p][i] = $urandom;
    push_model(b);
    for (int p = 0; p < NP; p++) idx[p] = 0;
    drv_en = 1;
    @(posedge clock); #1;
    start = 1; z_start = zs; base = b;
    @(posedge clock); #1;
    start = 0; z_start = 0; base = $urandom;
  endtask

  task automatic run_wait();
    int n = 0;
    while (!fin && n < 3000) begin
      @(negedge clock);
      n++;
    end
    chk("finished reached", fin, 1);
    repeat (3) @(negedge clock);
    chk("addr queue drained", aq.size(), 0);
    chk("beat queue drained", bq.size(), 0);
    drv_en = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1; drv_en = 0; pvalid = '0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    aq.delete(); bq.delete();
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("rst ready", pready, 0);
    chk("rst addr valid", mav, 0);
    chk("rst block valid", mbv, 0);
    chk("rst last", mlast, 0);
    chk("rst finished", fin, 0);
    chk("rst addr", maddr, 0);
    chk("rst len", mlen, 0);
    chk("rst block", mblk, 0);

    vmode = 0; rmode = 0;
    run_start(64'h1000, 1);
    chk("zero-output finished", z_fin, 1);
    @(posedge clock); #1;
    chk("zero-output finished held", z_fin, 1);
    run_wait();

    @(posedge clock); #1 start = 1;
    @(posedge clock); #1 start = 0;
    repeat (20) @(negedge clock);
    chk("start ignored in DONE", fin, 1);

    do_reset();
    vmode = 1; rmode = 1; stall_a = 5; stall_b = 10;
    run_start({$urandom, $urandom} & ~64'h3f, 0);
    run_wait();

    do_reset();
    vmode = 1; rmode = 0;
    run_start({$urandom, $urandom} & ~64'h3f, 0);
    n = 0;
    while (!mbv && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("reached WRITE before reset", mbv, 1);
    @(posedge clock); #1;
    reset = 1; drv_en = 0; pvalid = '0;
    for (int p = 0; p < NP; p++) idx[p] = 0;
    @(posedge clock); #1;
    chk("mid reset addr valid", mav, 0);
    chk("mid reset block valid", mbv, 0);
    chk("mid reset ready", pready, 0);
    chk("mid reset finished", fin, 0);
    chk("mid reset last", mlast, 0);
    aq.delete(); bq.delete();
    reset = 0;
    rmode = 1;
    run_start(64'hFFFF_FFFF_FFFF_FFC0, 0);
    run_wait();

    chk("zero-output dut idle on bus", z_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
